lcd_controller: RTL and testbench

- Peripheral end of the CPU's LCD port: accepts the 10-bit command word and `start` strobe driven by the data-memory side, and returns the `finish` strobe to it.
- Drives an HD44780-compatible character LCD through its 8-bit parallel write interface.
- Runs the power-on init sequence by itself after reset.
- Applies the per-command setup, enable-pulse, hold and execution timing, then pulses `finish` once per accepted command.

---
 rtl/lcd_controller.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// HD44780-compatible character LCD write controller.
//
// Accepts a 10-bit command word with a start strobe and drives the LCD's 8-bit parallel write
// interface, including setup, enable pulse, hold and execution wait timing. After reset it
// runs the power-on init sequence by itself (when INIT_EN=1). Each command accepted in IDLE
// ends with a one-cycle finish pulse. All outputs are registered.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      command request, sampled only in IDLE
//   lcd_data   command word: [9]=RS, [8]=RW (ignored, always written), [7:0]=DB
//   finish     one-cycle pulse when an accepted command completes
//   busy       high whenever the controller is not idle
//   init_done  high once the init sequence has completed
//   lcd_e      LCD enable
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, tied to write
//   lcd_db     LCD data bus
module lcd_controller #(
  parameter bit          INIT_EN     = 1'b1,
  parameter int unsigned T_POWERON   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EPULSE    = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] lcd_data,
  output logic       finish,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  // One shared counter sized for the longest wait; it only ever counts 0..T-1.
  localparam int unsigned MaxA = (T_POWERON > T_EXEC_LONG) ? T_POWERON : T_EXEC_LONG;
  localparam int unsigned MaxB = (T_SETUP > T_EPULSE) ? T_SETUP : T_EPULSE;
  localparam int unsigned MaxC = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int unsigned MaxBC = (MaxB > MaxC) ? MaxB : MaxC;
  localparam int unsigned MaxT = (MaxA > MaxBC) ? MaxA : MaxBC;
  localparam int unsigned CntW = (MaxT > 1) ? $clog2(MaxT) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t PwrLast   = cnt_t'(T_POWERON - 1);
  localparam cnt_t SetupLast = cnt_t'(T_SETUP - 1);
  localparam cnt_t EpLast    = cnt_t'(T_EPULSE - 1);
  localparam cnt_t HoldLast  = cnt_t'(T_HOLD - 1);
  localparam cnt_t ExecLast  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LongLast  = cnt_t'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    StPwr,
    StSetup,
    StEpulse,
    StHold,
    StExec,
    StDone,
    StIdle
  } state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       in_init_q, in_init_d;
  logic       rs_q, rs_d;
  logic [7:0] db_q, db_d;
  logic       e_q, e_d;
  logic       finish_q, finish_d;
  logic       busy_q, busy_d;
  logic       init_done_q, init_done_d;
  logic       exec_long;
  cnt_t       exec_last;

  // Read requests are performed as writes, so the RW bit is intentionally dropped.
  logic unused_rw;
  assign unused_rw = lcd_data[8];

  function automatic logic [7:0] init_word(logic [1:0] idx);
    logic [7:0] w;
    unique case (idx)
      2'd0:    w = 8'h38;  // function set
      2'd1:    w = 8'h0C;  // display on
      2'd2:    w = 8'h01;  // clear
      default: w = 8'h06;  // entry mode
    endcase
    return w;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign exec_long = !rs_q && ((db_q == 8'h01) || (db_q[7:1] == 7'b0000001));
  assign exec_last = exec_long ? LongLast : ExecLast;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_init_d   = in_init_q;
    rs_d        = rs_q;
    db_d        = db_q;
    e_d         = 1'b0;
    finish_d    = 1'b0;
    init_done_d = init_done_q;

    unique case (state_q)
      StPwr: begin
        if (cnt_q == PwrLast) begin
          state_d = StSetup;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          db_d    = init_word(2'd0);
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StEpulse;
          e_d     = 1'b1;
        end
      end
      StEpulse: begin
        e_d = 1'b1;
        if (cnt_q == EpLast) begin
          state_d = StHold;
          e_d     = 1'b0;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == exec_last) begin
          if (!in_init_q) begin
            state_d  = StDone;
            finish_d = 1'b1;
          end else if (idx_q == 2'd3) begin
            state_d     = StIdle;
            in_init_d   = 1'b0;
            init_done_d = 1'b1;
          end else begin
            state_d = StSetup;
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            db_d    = init_word(idx_q + 2'd1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          rs_d    = lcd_data[9];
          db_d    = lcd_data[7:0];
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q + cnt_t'(1);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_EN ? StPwr : StIdle;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      in_init_q   <= INIT_EN;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
      e_q         <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= INIT_EN;
      init_done_q <= !INIT_EN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_init_q   <= in_init_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      e_q         <= e_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign finish    = finish_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_e     = e_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller: one instance with the init sequence, one without.
module tb_lcd_controller;

  localparam int unsigned TPwr  = 20;
  localparam int unsigned TSet  = 2;
  localparam int unsigned TEp   = 4;
  localparam int unsigned THold = 2;
  localparam int unsigned TEx   = 10;
  localparam int unsigned TExL  = 40;

  logic       clk;
  logic       rst1, start1, finish1, busy1, init_done1, e1, rs1, rw1;
  logic [9:0] data1;
  logic [7:0] db1;
  logic       rst0, start0, finish0, busy0, init_done0, e0, rs0, rw0;
  logic [9:0] data0;
  logic [7:0] db0;

  int tests = 0;
  int fails = 0;
  int fin1  = 0;
  logic [8:0] e_log[$];

  lcd_controller #(
    .INIT_EN(1'b1), .T_POWERON(TPwr), .T_SETUP(TSet), .T_EPULSE(TEp), .T_HOLD(THold),
    .T_EXEC(TEx), .T_EXEC_LONG(TExL)
  ) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .lcd_data(data1), .finish(finish1), .busy(busy1),
    .init_done(init_done1), .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_db(db1)
  );

  lcd_controller #(
    .INIT_EN(1'b0), .T_POWERON(TPwr), .T_SETUP(TSet), .T_EPULSE(TEp), .T_HOLD(THold),
    .T_EXEC(TEx), .T_EXEC_LONG(TExL)
  ) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .lcd_data(data0), .finish(finish0), .busy(busy0),
    .init_done(init_done0), .lcd_e(e0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_db(db0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: latency from the accept edge to the finish cycle, from the command rules.
  function automatic int model_lat(input logic [9:0] w);
    logic [7:0] db;
    bit         long_cmd;
    db       = w[7:0];
    long_cmd = !w[9] && (db == 8'h01 || db == 8'h02 || db == 8'h03);
    return TSet + TEp + THold + (long_cmd ? TExL : TEx);
  endfunction

  // Bus monitor for dut1: logs {RS,DB} at every E rise and checks pulse shape.
  initial begin : mon
    logic       prev_e;
    logic [8:0] prev_bus, cur_bus, pulse_bus;
    int         width, stable, hold_left;
    prev_e = 1'b0; prev_bus = '0; pulse_bus = '0; width = 0; stable = 0; hold_left = 0;
    forever begin
      @(negedge clk);
      check("lcd_rw", {30'd0, rw1, rw0}, 32'd0);
      cur_bus = {rs1, db1};
      if (!rst1) begin
        prev_e = 1'b0; width = 0; stable = 0; hold_left = 0; prev_bus = cur_bus;
      end else begin
        stable = (cur_bus == prev_bus) ? stable + 1 : 1;
        if (e1 && !prev_e) begin
          e_log.push_back(cur_bus);
          pulse_bus = cur_bus;
          width = 1;
          check("setup_stable", {31'd0, stable >= int'(TSet + 1)}, 32'd1);
        end else if (e1) begin
          width++;
          check("bus_in_pulse", {23'd0, cur_bus}, {23'd0, pulse_bus});
        end else if (prev_e) begin
          check("e_width", width, TEp);
          check("bus_hold", {23'd0, cur_bus}, {23'd0, pulse_bus});
          hold_left = THold - 1;
        end else if (hold_left > 0) begin
          check("bus_hold", {23'd0, cur_bus}, {23'd0, pulse_bus});
          hold_left--;
        end
        if (finish1) fin1++;
        prev_e = e1;
        prev_bus = cur_bus;
      end
    end
  end

  // Release dut1 from reset and check the whole init sequence.
  task automatic init_seq(input string tag);
    logic [8:0] iw[4];
    int got, f0;
    iw = '{9'h038, 9'h00C, 9'h001, 9'h006};
    e_log.delete();
    f0 = fin1;
    got = -1;
    rst1 = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (init_done1) begin
        got = j;
        break;
      end
    end
    check({tag, "_done_cycle"}, got, TPwr + 3 * (TSet + TEp + THold + TEx) +
          (TSet + TEp + THold + TExL));
    check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_pulses"}, e_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < e_log.size()) check({tag, "_word"}, {23'd0, e_log[i]}, {23'd0, iw[i]});
    end
    check({tag, "_no_finish"}, fin1 - f0, 0);
    e_log.delete();
  endtask

  // Issue a command to dut1; optional junk start pulses at negedges na/nb after accept.
  task automatic issue(input logic [9:0] w, input int na, input int nb, output int lat);
    lat = -1;
    for (int j = 0; j < 200 && busy1; j++) @(negedge clk);
    start1 = 1'b1;
    data1 = w;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (j == na || j == nb) begin
        start1 = 1'b1;
        data1 = 10'h255;
      end
      if (finish1 && lat < 0) lat = j - 1;
      if (lat >= 0 && j > lat + 2) break;
    end
    start1 = 1'b0;
  endtask

  task automatic do_cmd(input string name, input logic [9:0] w, input int na, input int nb,
                        input int exp_lat, input logic [8:0] exp_bus);
    int lat, f0;
    f0 = fin1;
    e_log.delete();
    issue(w, na, nb, lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_finish_count"}, fin1 - f0, 1);
    check({name, "_pulses"}, e_log.size(), 1);
    if (e_log.size() > 0) check({name, "_bus"}, {23'd0, e_log[0]}, {23'd0, exp_bus});
    e_log.delete();
  endtask

  task automatic issue0(input logic [9:0] w, output int lat, output int ehi);
    lat = -1;
    ehi = 0;
    start0 = 1'b1;
    data0 = w;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (e0) ehi++;
      if (finish0 && lat < 0) lat = j - 1;
      if (lat >= 0 && j > lat + 1) break;
    end
    start0 = 1'b0;
  endtask

  typedef struct {
    logic [9:0] word;
    int         lat;
    logic [8:0] bus;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[10];
    int lat, ehi, f0, nf, last, na;
    logic [9:0] w;

    vecs[0] = '{10'h241, 18, 9'h141};
    vecs[1] = '{10'h001, 48, 9'h001};
    vecs[2] = '{10'h003, 48, 9'h003};
    vecs[3] = '{10'h004, 18, 9'h004};
    vecs[4] = '{10'h002, 48, 9'h002};
    vecs[5] = '{10'h000, 18, 9'h000};
    vecs[6] = '{10'h201, 18, 9'h101};
    vecs[7] = '{10'h141, 18, 9'h041};
    vecs[8] = '{10'h101, 48, 9'h001};
    vecs[9] = '{10'h3FF, 18, 9'h1FF};

    rst1 = 1'b1; rst0 = 1'b1;
    start1 = 1'b0; start0 = 1'b0; data1 = '0; data0 = '0;
    #1;
    rst1 = 1'b0; rst0 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst1_outs", {21'd0, e1, rs1, db1, finish1}, 32'd0);
    check("rst1_busy_idone", {30'd0, busy1, init_done1}, 32'd2);
    check("rst0_busy_idone", {30'd0, busy0, init_done0}, 32'd1);
    check("rst0_outs", {21'd0, e0, rs0, db0, finish0}, 32'd0);

    init_seq("init");

    // Table vectors
    foreach (vecs[i]) do_cmd($sformatf("vec%0d", i), vecs[i].word, 0, 0, vecs[i].lat,
                             vecs[i].bus);

    // Junk starts during EPULSE and DONE must be ignored
    do_cmd("busy_rej", 10'h241, 4, 19, 18, 9'h141);
    check("busy_rej_db", {23'd0, rs1, db1}, 32'h141);

    // start held high: each command accepted on the first IDLE cycle
    f0 = fin1;
    e_log.delete();
    start1 = 1'b1;
    data1 = 10'h241;
    nf = 0;
    last = 0;
    for (int j = 1; j <= 200 && nf < 3; j++) begin
      @(negedge clk);
      if (finish1) begin
        nf++;
        if (nf == 1) check("b2b_first", j - 1, 18);
        else check("b2b_gap", j - last, 20);
        last = j;
        if (nf == 3) start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    check("b2b_count", nf, 3);
    repeat (5) @(negedge clk);
    check("b2b_pulses", e_log.size(), 3);
    check("b2b_finish_count", fin1 - f0, 3);
    check("b2b_idle", {31'd0, busy1}, 32'd0);
    e_log.delete();

    // Randomized commands against the latency/bus model
    for (int k = 0; k < 24; k++) begin
      w = 10'($urandom);
      if ($urandom_range(0, 1) == 1) w = {1'b0, w[8], 6'b0, w[1:0]};
      na = $urandom_range(0, model_lat(w) + 1);
      do_cmd($sformatf("rnd%0d_%03h", k, w), w, na, 0, model_lat(w), {w[9], w[7:0]});
    end

    // Reset during EPULSE aborts at once
    start1 = 1'b1;
    data1 = 10'h241;
    @(negedge clk);
    start1 = 1'b0;
    nf = 0;
    for (int j = 0; j < 20 && !e1; j++) @(negedge clk);
    check("midrst_in_pulse", {31'd0, e1}, 32'd1);
    #2;
    rst1 = 1'b0;
    #1;
    check("midrst_e", {31'd0, e1}, 32'd0);
    check("midrst_finish", {31'd0, finish1}, 32'd0);
    check("midrst_busy", {31'd0, busy1}, 32'd1);
    check("midrst_idone", {31'd0, init_done1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    init_seq("reinit");

    // INIT_EN=0 instance
    rst0 = 1'b1;
    @(negedge clk);
    check("noinit_busy", {31'd0, busy0}, 32'd0);
    check("noinit_idone", {31'd0, init_done0}, 32'd1);
    issue0(10'h241, lat, ehi);
    check("noinit_latency", lat, 18);
    check("noinit_ehigh", ehi, TEp);
    check("noinit_bus", {23'd0, rs0, db0}, 32'h141);
    issue0(10'h002, lat, ehi);
    check("noinit_long_latency", lat, 48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
